// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use, memory wait, branch flush, halt.
// Optional stall-cycle counter selected by HAZARD_PERF_EN.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_RW,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        mem_req,
  input  logic        br_taken,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        halted,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH, HALTED} state_t;

  state_t state_q, state_d;
  logic   load_use;
  logic   mem_wait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign load_use = ex_dREN && (ex_RW != 5'd0) &&
                    ((ex_RW == id_rs) || (id_uses_rt && (ex_RW == id_rt)));

  // Once waiting, only dhit releases the stall; mem_req need not stay asserted.
  assign mem_wait = (state_q == MEMWAIT) ? !dhit : (mem_req && !dhit);

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    halted      = 1'b0;
    if (nRST) begin
      case (state_q)
        HALTED: begin
          halted      = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
        end
        FLUSH: begin
          if (wb_halt) begin
            state_d = HALTED;
          end else begin
            // Flush stays up until a fetch actually completes.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = ihit;
            state_d    = ihit ? RUN : FLUSH;
          end
        end
        default: begin
          if (wb_halt) begin
            state_d = HALTED;
          end else if (mem_wait) begin
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_d     = MEMWAIT;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = ihit;
            state_d    = ihit ? RUN : FLUSH;
          end else if (load_use) begin
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
          end else begin
            pc_en   = ihit;
            state_d = RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= 32'd0;
    end else if (!pc_en && (state_q != HALTED) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with a flag-based reference model.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, ex_dREN, id_uses_rt, mem_req, br_taken, wb_halt;
  logic [4:0]  ex_RW, id_rs, id_rt;
  logic        pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, halted;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, halted}
  logic [6:0] obs;
  assign obs = {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, halted};

  // Reference model: independent "processor is halted / waiting on memory / owes a flush" flags.
  logic        m_halted, m_memwait, m_flush;
  logic        nx_halted, nx_memwait, nx_flush;
  logic [31:0] m_cnt;
  logic [6:0]  exp_o;

  hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ex_dREN(ex_dREN), .ex_RW(ex_RW),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .mem_req(mem_req),
    .br_taken(br_taken), .wb_halt(wb_halt), .pc_en(pc_en), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic model_eval();
    logic hazard, waiting;
    hazard  = ex_dREN && ex_RW != 0 && (ex_RW == id_rs || (id_uses_rt && ex_RW == id_rt));
    waiting = m_memwait ? !dhit : (mem_req && !dhit);
    nx_halted = m_halted; nx_memwait = m_memwait; nx_flush = m_flush;
    if (!nRST)         exp_o = 7'b0000000;
    else if (m_halted) exp_o = 7'b0101011;
    else if (wb_halt) begin
      exp_o = 7'b0000000; nx_halted = 1'b1;
    end else if (m_flush) begin
      exp_o = {ihit, 6'b010100}; nx_flush = !ihit;
    end else if (waiting) begin
      exp_o = 7'b0101010; nx_memwait = 1'b1;
    end else begin
      nx_memwait = 1'b0;
      if (br_taken) begin
        exp_o = {ihit, 6'b010100}; nx_flush = !ihit;
      end else if (hazard) exp_o = 7'b0100100;
      else                 exp_o = {ihit, 6'b000000};
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLK);
    if (nRST) begin
`ifdef HAZARD_PERF_EN
      if (!exp_o[6] && !m_halted && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      m_halted = nx_halted; m_memwait = nx_memwait; m_flush = nx_flush;
    end
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b0; ex_dREN = 1'b0; id_uses_rt = 1'b0; mem_req = 1'b0;
    br_taken = 1'b0; wb_halt = 1'b0; ex_RW = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    m_halted = 1'b0; m_memwait = 1'b0; m_flush = 1'b0; m_cnt = 32'd0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ihit = 1'b1; mem_req = 1'b1; br_taken = 1'b1;
    nRST = 1'b0;
    m_halted = 1'b0; m_memwait = 1'b0; m_flush = 1'b0; m_cnt = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 7'b0000000 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_outputs obs=%b cnt=%0d expected obs=0000000 cnt=0", obs, stall_cnt);
    end
    nRST = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL reset_first_run obs=%b expected 1000000", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_dREN = 1'b1; ex_RW = 5'd5; id_rs = 5'd5;
    #1;
    checks++;
    if (obs !== 7'b0100100) begin
      errors++; $display("FAIL load_use_rs obs=%b expected 0100100", obs);
    end
    tick();
    ex_dREN = 1'b0; ex_RW = 5'd0;   // bubble now in ID/EX
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL load_use_cleared obs=%b expected 1000000", obs);
    end
    tick();
    ex_dREN = 1'b1; ex_RW = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0100100) begin
      errors++; $display("FAIL load_use_rt obs=%b expected 0100100", obs);
    end
    id_uses_rt = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL load_use_rt_unused obs=%b expected 1000000", obs);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    ex_dREN = 1'b1; ex_RW = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL zero_reg obs=%b expected 1000000", obs);
    end
    tick();
    mem_req = 1'b1; dhit = 1'b1; ex_dREN = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL mem_hit_no_stall obs=%b expected 1000000", obs);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [31:0] base;
    clear_inputs();
    base = stall_cnt;
    mem_req = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_req = 1'b0;   // wait must persist on dhit alone
      #1;
      checks++;
      if (obs !== 7'b0101010) begin
        errors++; $display("FAIL mem_wait_stall cycle=%0d obs=%b expected 0101010", i, obs);
      end
      tick();
    end
    dhit = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL mem_wait_release obs=%b expected 1000000", obs);
    end
    tick();
    dhit = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL mem_wait_back_to_run obs=%b expected 1000000", obs);
    end
    checks++;
`ifdef HAZARD_PERF_EN
    if (stall_cnt !== base + 32'd3) begin
      errors++; $display("FAIL mem_wait_count got=%0d expected=%0d", stall_cnt, base + 32'd3);
    end
`else
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL mem_wait_count got=%0d expected=0 base=%0d", stall_cnt, base);
    end
`endif
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    br_taken = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs !== 7'b0010100) begin
        errors++; $display("FAIL branch_wait cycle=%0d obs=%b expected 0010100", i, obs);
      end
      tick();
    end
    br_taken = 1'b0; ihit = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1010100) begin
      errors++; $display("FAIL branch_ihit obs=%b expected 1010100", obs);
    end
    tick();
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL branch_back_to_run obs=%b expected 1000000", obs);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    wb_halt = 1'b1; mem_req = 1'b1; dhit = 1'b0; br_taken = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_same_cycle pc_en=%b halted=%b expected 0 0", pc_en, halted);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      wb_halt = 1'(i[0]); mem_req = $urandom_range(0, 1); dhit = $urandom_range(0, 1);
      br_taken = $urandom_range(0, 1); ihit = $urandom_range(0, 1);
      ex_dREN = 1'b1; ex_RW = 5'd4; id_rs = 5'd4;
      #1;
      checks++;
      if (obs !== 7'b0101011) begin
        errors++; $display("FAIL halted_sticky cycle=%0d obs=%b expected 0101011", i, obs);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    clear_inputs();
    mem_req = 1'b1;
    tick(); tick();
    nRST = 1'b0;
    m_halted = 1'b0; m_memwait = 1'b0; m_flush = 1'b0; m_cnt = 32'd0;
    #1;
    checks++;
    if (obs !== 7'b0000000 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_mid_memwait obs=%b cnt=%0d expected 0000000 0", obs, stall_cnt);
    end
    @(posedge CLK); #1;
    nRST = 1'b1; mem_req = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++; $display("FAIL post_reset_run obs=%b expected 1000000", obs);
    end
    tick();
    br_taken = 1'b1; ihit = 1'b0;
    tick();
    br_taken = 1'b0;
    apply_reset();
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL post_flush_reset_run obs=%b expected 0000000", obs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ihit = ($urandom_range(0, 3) != 0); dhit = $urandom_range(0, 1);
      ex_dREN = $urandom_range(0, 1); ex_RW = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = $urandom_range(0, 1); mem_req = $urandom_range(0, 1);
      br_taken = ($urandom_range(0, 3) == 0); wb_halt = ($urandom_range(0, 59) == 0);
      if (m_halted && $urandom_range(0, 7) == 0) apply_reset();
      #1;
      model_eval();
      checks++;
      if (obs !== exp_o || stall_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random cycle=%0d obs=%b expected=%b cnt=%0d expected_cnt=%0d", i, obs, exp_o, stall_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_branch();
    test_priority();
    test_reset_mid_op();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
